// File: rtl/ddr_fifo_pkg.sv
// Pointer helpers shared by both sides of the DDR wishbone slave async FIFO.
// Functions work on a wide zero-extended value so any pointer width up to PTR_MAX fits.
package ddr_fifo_pkg;

  localparam int PTR_MAX = 16;

  typedef logic [PTR_MAX-1:0] ptr_max_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Zero upper bits leave the prefix XOR of the live bits unchanged.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input ptr_max_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PTR_MAX; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ddr_gray_sync.sv
// Two-flop synchroniser for a Gray pointer followed by a registered Gray-to-binary decode.
module ddr_gray_sync
  import ddr_fifo_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear_in,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_sync_out,
  output logic [WIDTH-1:0] bin_out
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;

  assign bin_next = WIDTH'(gray2bin(ptr_max_t'(s2_reg)));

  // s1 -> s2 is a bare flop pair so the metastable stage has a full cycle to settle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_reg  <= '0;
      s2_reg  <= '0;
      bin_reg <= '0;
    end else if (Clear_in) begin
      s1_reg  <= '0;
      s2_reg  <= '0;
      bin_reg <= '0;
    end else begin
      s1_reg  <= gray_in;
      s2_reg  <= s1_reg;
      bin_reg <= bin_next;
    end
  end

  assign gray_sync_out = s2_reg;
  assign bin_out       = bin_reg;

endmodule

// File: rtl/ddr_gray_ptr_receiver.sv
// Read-side pointer logic of the DDR async FIFO: synchronises the write pointer,
// tracks the read pointer and produces level, empty, underflow and coherence-error flags.
module ddr_gray_ptr_receiver
  import ddr_fifo_pkg::*;
#(
  parameter  int ADDR_WIDTH = 2,
  localparam int PTR_WIDTH  = ptr_width(ADDR_WIDTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Clear_in,
  input  logic [PTR_WIDTH-1:0]  WrGray_in,
  input  logic                  ReadEn_in,
  output logic                  Pop_out,
  output logic [ADDR_WIDTH-1:0] RdAddr_out,
  output logic [PTR_WIDTH-1:0]  RdGray_out,
  output logic [PTR_WIDTH-1:0]  Level_out,
  output logic                  Empty_out,
  output logic                  Underflow_out,
  output logic                  Error_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PTR_WIDTH-1:0] wr_gray_sync;
  logic [PTR_WIDTH-1:0] wr_bin_reg;
  logic [PTR_WIDTH-1:0] wr_bin_next;
  logic [PTR_WIDTH-1:0] wr_gray_prev;
  logic [PTR_WIDTH-1:0] rd_bin_reg;
  logic [PTR_WIDTH-1:0] rd_bin_next;
  logic [PTR_WIDTH-1:0] level_next;
  logic                 hamming_bad;
  logic                 level_bad;

  ddr_gray_sync #(
    .WIDTH(PTR_WIDTH)
  ) u_sync (
    .Clk          (Clk),
    .Reset        (Reset),
    .Clear_in     (Clear_in),
    .gray_in      (WrGray_in),
    .gray_sync_out(wr_gray_sync),
    .bin_out      (wr_bin_reg)
  );

  // wr_bin_reg is the decode of last cycle's synchronised value, so re-encoding it
  // recovers the previous s2 without a separate history register.
  assign wr_gray_prev = PTR_WIDTH'(bin2gray(ptr_max_t'(wr_bin_reg)));
  assign wr_bin_next  = PTR_WIDTH'(gray2bin(ptr_max_t'(wr_gray_sync)));

  assign Pop_out     = ReadEn_in & ~Empty_out;
  assign rd_bin_next = rd_bin_reg + PTR_WIDTH'(Pop_out);
  assign level_next  = wr_bin_next - rd_bin_next;

  assign hamming_bad = popcount(ptr_max_t'(wr_gray_sync ^ wr_gray_prev)) > 1;
  assign level_bad   = level_next > PTR_WIDTH'(DEPTH);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_bin_reg    <= '0;
      RdGray_out    <= '0;
      Level_out     <= '0;
      Empty_out     <= 1'b1;
      Underflow_out <= 1'b0;
      Error_out     <= 1'b0;
    end else if (Clear_in) begin
      rd_bin_reg    <= '0;
      RdGray_out    <= '0;
      Level_out     <= '0;
      Empty_out     <= 1'b1;
      Underflow_out <= 1'b0;
      Error_out     <= 1'b0;
    end else begin
      rd_bin_reg    <= rd_bin_next;
      RdGray_out    <= PTR_WIDTH'(bin2gray(ptr_max_t'(rd_bin_next)));
      Level_out     <= level_next;
      Empty_out     <= (level_next == '0);
      Underflow_out <= ReadEn_in & Empty_out;
      Error_out     <= Error_out | hamming_bad | level_bad;
    end
  end

  assign RdAddr_out = rd_bin_reg[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_ddr_gray_ptr_receiver.sv
// Self-checking bench for ddr_gray_ptr_receiver: directed and random pushes/pops
// compared against an occupancy-counting model with a two-sample write visibility delay.
module tb_ddr_gray_ptr_receiver;

  logic       Clk;
  logic       Reset;
  logic       Clear_in;
  logic [2:0] WrGray_in;
  logic       ReadEn_in;
  logic       Pop_out;
  logic [1:0] RdAddr_out;
  logic [2:0] RdGray_out;
  logic [2:0] Level_out;
  logic       Empty_out;
  logic       Underflow_out;
  logic       Error_out;

  ddr_gray_ptr_receiver #(
    .ADDR_WIDTH(2)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Clear_in     (Clear_in),
    .WrGray_in    (WrGray_in),
    .ReadEn_in    (ReadEn_in),
    .Pop_out      (Pop_out),
    .RdAddr_out   (RdAddr_out),
    .RdGray_out   (RdGray_out),
    .Level_out    (Level_out),
    .Empty_out    (Empty_out),
    .Underflow_out(Underflow_out),
    .Error_out    (Error_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Model: counts of writes issued and reads done; d0/d1 hold the write count sampled
  // on the last two edges, since a write needs two more edges before it counts.
  int wcnt, rcnt, d0, d1, exp_level;
  bit exp_empty;

  function automatic logic [2:0] tb_gray(input int n);
    int b;
    b = n % 8;
    return 3'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; d0 = 0; d1 = 0; exp_level = 0; exp_empty = 1'b1;
  endtask

  task automatic step(input bit ren);
    bit pop;
    bit uf;
    int visible;
    @(negedge Clk);
    WrGray_in = tb_gray(wcnt);
    ReadEn_in = ren;
    #1;
    pop = ren && !exp_empty;
    chk("pop", 32'(Pop_out), 32'(pop));
    @(posedge Clk);
    #1;
    visible = d1;
    d1 = d0;
    d0 = wcnt;
    uf = ren && exp_empty;
    rcnt += int'(pop);
    exp_level = visible - rcnt;
    exp_empty = (exp_level == 0);
    chk("level", 32'(Level_out), 32'(exp_level));
    chk("empty", 32'(Empty_out), 32'(exp_empty));
    chk("underflow", 32'(Underflow_out), 32'(uf));
    chk("rdaddr", 32'(RdAddr_out), 32'(rcnt % 4));
    chk("rdgray", 32'(RdGray_out), 32'(tb_gray(rcnt)));
    chk("error", 32'(Error_out), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_level"}, 32'(Level_out), 32'd0);
    chk({tag, "_empty"}, 32'(Empty_out), 32'd1);
    chk({tag, "_rdgray"}, 32'(RdGray_out), 32'd0);
    chk({tag, "_rdaddr"}, 32'(RdAddr_out), 32'd0);
    chk({tag, "_uf"}, 32'(Underflow_out), 32'd0);
    chk({tag, "_error"}, 32'(Error_out), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge Clk);
    Clear_in  = 1'b1;
    WrGray_in = 3'b000;
    ReadEn_in = 1'b1;
    @(posedge Clk);
    #1;
    check_reset_values("clear");
    Clear_in  = 1'b0;
    ReadEn_in = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] addr_before;
    int hold;
    Reset = 1'b0; Clear_in = 1'b0; WrGray_in = 3'b000; ReadEn_in = 1'b0;
    model_reset();

    // Async reset between edges, then idle with a zero write pointer
    #2 Reset = 1'b1;
    #1 check_reset_values("rst_async");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) step(1'b0);

    // First write: visible on the third edge
    wcnt = 1;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("first_write_level", 32'(Level_out), 32'd1);

    // Fill to 4, then pop five times; the fifth underflows
    for (int i = 2; i <= 4; i++) begin
      wcnt = i;
      step(1'b0);
    end
    repeat (2) step(1'b0);
    chk("full_level", 32'(Level_out), 32'd4);
    repeat (5) step(1'b1);
    step(1'b0);

    // Wrap: one write and a pop per cycle across two pointer wraps
    for (int i = 0; i < 12; i++) begin
      wcnt++;
      step(1'b1);
      chk("wrap_lvl_le1", 32'(Level_out <= 3'd1), 32'd1);
    end
    repeat (3) step(1'b1);

    // Pop coincides with a write landing at level 2
    do_clear();
    wcnt = 1; step(1'b0);
    wcnt = 2; step(1'b0);
    repeat (2) step(1'b0);
    chk("pre_simul_level", 32'(Level_out), 32'd2);
    addr_before = RdAddr_out;
    wcnt = 3; step(1'b0);
    step(1'b0);
    step(1'b1);
    chk("simul_level", 32'(Level_out), 32'd2);
    chk("simul_addr", 32'(RdAddr_out), 32'(addr_before + 2'd1));

    // Incoherent Gray jump raises a sticky error
    do_clear();
    @(negedge Clk);
    WrGray_in = 3'b011;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    chk("err_set", 32'(Error_out), 32'd1);
    @(negedge Clk);
    WrGray_in = 3'b010;
    repeat (4) begin
      @(posedge Clk);
      #1;
    end
    chk("err_sticky", 32'(Error_out), 32'd1);
    do_clear();
    repeat (2) step(1'b0);

    // Random pushes and pops, never exceeding four in flight
    for (int i = 0; i < 300; i++) begin
      hold = int'($urandom_range(0, 1));
      if ((wcnt - rcnt) < 4 && hold == 1) wcnt++;
      step(1'($urandom_range(0, 1)));
    end

    // Async reset mid-operation
    while (wcnt - rcnt < 2) begin
      wcnt++;
      step(1'b0);
    end
    repeat (3) step(1'b0);
    @(negedge Clk);
    #3;
    Reset = 1'b1;
    WrGray_in = 3'b000;
    ReadEn_in = 1'b0;
    #1 check_reset_values("rst_midop");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    repeat (3) step(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
